// File: rtl/tile_writer_pkg.sv
// Shared tile layout and writer FSM definitions.
// The read-side colour lookup imports this package as well, so both ends use one layout.
package tile_writer_pkg;

    localparam int unsigned TILE_DIM     = 8;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned TILE_W       = 512;
    localparam int unsigned TILE_COUNT   = 16;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned PIX_PER_TILE = TILE_DIM * TILE_DIM;
    localparam int unsigned CNT_W        = 6;

    // RGB332 field positions within a pixel byte
    localparam int unsigned R_LSB = 0;
    localparam int unsigned G_LSB = 3;
    localparam int unsigned B_LSB = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

endpackage

// File: rtl/tile_writer_pack_buffer.sv
// 64x8 byte-addressable pack register with synchronous clear and a flat 512-bit view.
// Byte k occupies bits [8k+7:8k], so pixel (r, c) lands at bit offset 64r+8c.
module tile_pack_buffer
    import tile_writer_pkg::*;
(
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                we,
    input  logic [CNT_W-1:0]    addr,
    input  logic [PIX_W-1:0]    din,
    output logic [TILE_W-1:0]   data
);

    logic [TILE_W-1:0] data_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (clr) begin
            data_q <= '0;
        end else if (we) begin
            data_q[{addr, 3'b000} +: PIX_W] <= din;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/tile_writer.sv
// Collects one 8x8 RGB332 tile over a valid/ready stream and writes it to the tile store
// as a single 512-bit word. All outputs decode directly from flops.
module tile_writer
    import tile_writer_pkg::*;
(
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IDX_W-1:0]    tile_idx,
    input  logic                abort,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [PIX_W-1:0]    pix_data,
    output logic                wr_en,
    output logic [IDX_W-1:0]    wr_addr,
    output logic [TILE_W-1:0]   wr_data,
    output logic                busy,
    output logic                done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               accept;
    logic               hs;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                idx_q <= tile_idx;
            end else if (hs) begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hs        = 1'b0;
        pix_ready = 1'b0;
        busy      = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = start && !abort;
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                // abort beats a same-cycle handshake; that pixel is dropped
                hs = pix_valid && !abort;
                if (abort) begin
                    state_d = IDLE;
                end else if (hs && cnt_q == CNT_W'(PIX_PER_TILE - 1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_addr = idx_q;

    tile_pack_buffer u_buf (
        .clk1  (clk1),
        .rst_n (rst_n),
        .clr   (accept),
        .we    (hs),
        .addr  (cnt_q),
        .din   (pix_data),
        .data  (wr_data)
    );

endmodule

// File: tb/tb_tile_writer.sv
// Directed bench for tile_writer: border, stalled, ramp, abort, ignored-start and reset loads.
module tb_tile_writer;

    logic         clk1 = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   tile_idx = '0;
    logic         abort = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic [7:0]   pix_data = '0;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [511:0] wr_data;
    logic         busy;
    logic         done;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_err = 0;

    localparam logic [511:0] BORDER07 = {64'h0707070707070707, {6{64'h0700000000000007}},
                                         64'h0707070707070707};
    localparam logic [511:0] BORDER38 = {64'h3838383838383838, {6{64'h3800000000000038}},
                                         64'h3838383838383838};

    tile_writer dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .start     (start),
        .tile_idx  (tile_idx),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (wr_en) wr_cnt++;
        if (done !== wr_en) done_err++;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // kind 0: border of val, kind 1: ramp k, kind 2: constant val
    function automatic logic [7:0] pix_of(input int kind, input int k, input logic [7:0] val);
        int r;
        int c;
        r = k / 8;
        c = k % 8;
        if (kind == 0) return (r == 0 || r == 7 || c == 0 || c == 7) ? val : 8'h00;
        if (kind == 1) return 8'(k);
        return val;
    endfunction

    task automatic do_start(input logic [3:0] idx);
        start    = 1'b1;
        tile_idx = idx;
        @(posedge clk1); #1;
        start    = 1'b0;
        check("start_ready", pix_ready, 1'b1);
        check("start_busy", busy, 1'b1);
    endtask

    // Sends handshakes for pixels k0..k0+n-1; returns 1 ns after the last accepting edge.
    task automatic push(input int k0, input int n, input int kind, input logic [7:0] val,
                        input bit rnd);
        int k;
        int cyc;
        bit hs;
        k   = k0;
        cyc = 0;
        while (k < k0 + n && cyc < 2000) begin
            pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = pix_of(kind, k, val);
            hs        = pix_valid && pix_ready;
            @(posedge clk1); #1;
            if (hs) k++;
            cyc++;
        end
        pix_valid = 1'b0;
        if (k < k0 + n) check("push_timeout", 512'(k), 512'(k0 + n));
    endtask

    // Called in the cycle right after the final handshake.
    task automatic expect_write(input string tag, input logic [3:0] addr,
                                input logic [511:0] data, input int w0);
        check({tag, "_wr_en"}, wr_en, 1'b1);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_ready_low"}, pix_ready, 1'b0);
        check({tag, "_addr"}, wr_addr, addr);
        check({tag, "_data"}, wr_data, data);
        @(posedge clk1); #1;
        check({tag, "_wr_en_off"}, wr_en, 1'b0);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_pulses"}, 512'(wr_cnt - w0), 512'd1);
    endtask

    task automatic expect_reset_vals(input string tag);
        check({tag, "_ready"}, pix_ready, 1'b0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_addr"}, wr_addr, 4'd0);
        check({tag, "_data"}, wr_data, 512'd0);
    endtask

    initial begin
        logic [511:0] ramp;
        int w0;
        for (int k = 0; k < 64; k++) ramp[8*k +: 8] = 8'(k);

        #2 rst_n = 1'b0;
        #2 expect_reset_vals("rst");
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
        @(posedge clk1); #1;

        // border tile, continuous stream
        w0 = wr_cnt;
        do_start(4'd0);
        push(0, 64, 0, 8'h07, 1'b0);
        expect_write("border07", 4'd0, BORDER07, w0);

        // border tile with random valid gaps
        w0 = wr_cnt;
        do_start(4'd1);
        push(0, 64, 0, 8'h38, 1'b1);
        expect_write("border38", 4'd1, BORDER38, w0);

        // abort after 20 pixels, then full all-ones load
        w0 = wr_cnt;
        do_start(4'd7);
        push(0, 20, 2, 8'h5a, 1'b0);
        abort     = 1'b1;
        pix_valid = 1'b1;
        @(posedge clk1); #1;
        abort     = 1'b0;
        pix_valid = 1'b0;
        check("abort_ready", pix_ready, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (3) @(posedge clk1); #1;
        check("abort_no_write", 512'(wr_cnt - w0), 512'd0);
        w0 = wr_cnt;
        do_start(4'd3);
        push(0, 64, 2, 8'hff, 1'b0);
        expect_write("ones", 4'd3, {512{1'b1}}, w0);

        // start during LOAD ignored; counter must resume at pixel 10
        w0 = wr_cnt;
        do_start(4'd5);
        push(0, 10, 1, 8'h00, 1'b0);
        start    = 1'b1;
        tile_idx = 4'd9;
        @(posedge clk1); #1;
        start    = 1'b0;
        check("midstart_busy", busy, 1'b1);
        check("midstart_ready", pix_ready, 1'b1);
        push(10, 54, 1, 8'h00, 1'b0);
        expect_write("midstart", 4'd5, ramp, w0);

        // start together with abort in IDLE ignored
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        abort = 1'b0;
        check("startabort_busy", busy, 1'b0);
        check("startabort_ready", pix_ready, 1'b0);

        // reset at pixel 40, then a ramp load to slot 15
        w0 = wr_cnt;
        do_start(4'd2);
        push(0, 40, 2, 8'hc3, 1'b0);
        #2 rst_n = 1'b0;
        #1 expect_reset_vals("midrst");
        @(posedge clk1); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk1); #1;
        check("midrst_no_write", 512'(wr_cnt - w0), 512'd0);
        w0 = wr_cnt;
        do_start(4'd15);
        push(0, 64, 1, 8'h00, 1'b0);
        expect_write("ramp", 4'd15, ramp, w0);

        check("done_coincident", 512'(done_err), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
